// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch-control bundle between the core and pc_sequencer
// Purpose: groups the redirect/branch/return controls and the fetch PC/RAS
//          status so that the core and the sequencer connect through one port.
// Modports:
//   master - core side: drives the wb/branch/call/ret/stall controls and
//            observes the PC and RAS status
//   slave  - pc_sequencer side: the mirror image of master
// Signals:
//   wb_redirect_i, wb_pc_i        writeback redirect and its target
//   take_branch_i, branch_pc_i    resolved taken branch and its target
//   call_i, ret_i, stall_i        call push / return pop / hold PC
//   program_counter_o, is_valid_o current fetch address and its valid flag
//   ras_empty_o, ras_full_o       RAS occupancy flags
//   ras_overflow_o/underflow_o    one-cycle RAS error pulses
interface pc_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    logic                wb_redirect_i;
    logic [PC_WIDTH-1:0] wb_pc_i;
    logic                take_branch_i;
    logic [PC_WIDTH-1:0] branch_pc_i;
    logic                call_i;
    logic                ret_i;
    logic                stall_i;
    logic [PC_WIDTH-1:0] program_counter_o;
    logic                is_valid_o;
    logic                ras_empty_o;
    logic                ras_full_o;
    logic                ras_overflow_o;
    logic                ras_underflow_o;

    modport master (
        output wb_redirect_i, wb_pc_i, take_branch_i, branch_pc_i,
               call_i, ret_i, stall_i,
        input  program_counter_o, is_valid_o, ras_empty_o, ras_full_o,
               ras_overflow_o, ras_underflow_o
    );

    modport slave (
        input  wb_redirect_i, wb_pc_i, take_branch_i, branch_pc_i,
               call_i, ret_i, stall_i,
        output program_counter_o, is_valid_o, ras_empty_o, ras_full_o,
               ras_overflow_o, ras_underflow_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC generator with return-address stack
// Purpose: picks the next fetch address from (highest first) writeback
//          redirect, resolved branch, stall hold, RAS return, sequential
//          increment. Registered with one cycle of latency.
// Ports:
//   clk_i      rising-edge clock
//   reset_n_i  asynchronous active-low reset
//   bus        pc_sequencer_if.slave (controls in, PC and RAS status out)
// Parameters: PC_WIDTH, INC_VALUE, START_ADDR, RAS_DEPTH (power of 2, >=2)
// Build option: define PC_SEQ_RAS_WRAP_EN to let a push into a full RAS
//   overwrite the oldest entry; otherwise that push is dropped. Both cases
//   pulse ras_overflow_o and still take the branch.
module pc_sequencer #(
    parameter int PC_WIDTH   = 32,
    parameter int INC_VALUE  = 2,
    parameter int START_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_WIDTH-1:0] INC_C    = PC_WIDTH'(INC_VALUE);
    localparam logic [PC_WIDTH-1:0] START_C  = PC_WIDTH'(START_ADDR);
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);

    // Which source supplies the next PC this cycle.
    typedef enum logic [2:0] {
        SEL_REDIRECT,
        SEL_BRANCH,
        SEL_STALL,
        SEL_RET,
        SEL_UNDERFLOW,
        SEL_SEQ
    } sel_e;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]    sp_q, sp_d;      // next free slot; top is sp_q-1
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                empty_q, full_q;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                push_en;
    sel_e                sel;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] ras_top;

    assign pc_inc  = pc_q + INC_C;
    // Pointer arithmetic wraps because RAS_DEPTH is a power of two.
    assign ras_top = ras_q[sp_q - PTR_ONE];

    always_comb begin
        sel = SEL_SEQ;
        if (bus.wb_redirect_i) begin
            sel = SEL_REDIRECT;
        end else if (bus.take_branch_i) begin
            sel = SEL_BRANCH;
        end else if (bus.stall_i) begin
            sel = SEL_STALL;
        end else if (bus.ret_i) begin
            sel = (cnt_q != CNT_ZERO) ? SEL_RET : SEL_UNDERFLOW;
        end
    end

    always_comb begin
        pc_d    = pc_inc;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        unique case (sel)
            SEL_REDIRECT: pc_d = bus.wb_pc_i;
            SEL_BRANCH: begin
                pc_d = bus.branch_pc_i;
                if (bus.call_i) begin
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
`ifdef PC_SEQ_RAS_WRAP_EN
                        // When full, sp_q points at the oldest entry, so a
                        // circular write replaces exactly that one.
                        push_en = 1'b1;
                        sp_d    = sp_q + PTR_ONE;
`endif
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + PTR_ONE;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            SEL_STALL: pc_d = pc_q;
            SEL_RET: begin
                pc_d  = ras_top;
                sp_d  = sp_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end
            SEL_UNDERFLOW: unf_d = 1'b1;
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_q    <= START_C;
            valid_q <= 1'b0;
            sp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == CNT_ZERO);
            full_q  <= (cnt_d == CNT_FULL);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; the write slot is the pre-push pointer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push_en) begin
            ras_q[sp_q] <= pc_inc;
        end
    end

    assign bus.program_counter_o = pc_q;
    assign bus.is_valid_o        = valid_q;
    assign bus.ras_empty_o       = empty_q;
    assign bus.ras_full_o        = full_q;
    assign bus.ras_overflow_o    = ovf_q;
    assign bus.ras_underflow_o   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic clk_i = 1'b0;
    logic reset_n_i;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.PC_WIDTH(32)) bus ();

    pc_sequencer #(
        .PC_WIDTH(32), .INC_VALUE(2), .START_ADDR(0), .RAS_DEPTH(4)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        bus.wb_redirect_i = 1'b0;
        bus.wb_pc_i       = '0;
        bus.take_branch_i = 1'b0;
        bus.branch_pc_i   = '0;
        bus.call_i        = 1'b0;
        bus.ret_i         = 1'b0;
        bus.stall_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.wb_redirect_i = 1'b1;
        bus.wb_pc_i       = pc;
        tick();
    endtask

    task automatic call_to(input logic [31:0] tgt);
        bus.take_branch_i = 1'b1;
        bus.branch_pc_i   = tgt;
        bus.call_i        = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset_n_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        checks++;
        if (bus.program_counter_o !== 32'h0 || bus.is_valid_o !== 1'b0 ||
            bus.ras_empty_o !== 1'b1 || bus.ras_full_o !== 1'b0 ||
            bus.ras_overflow_o !== 1'b0 || bus.ras_underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h valid=%b empty=%b full=%b ovf=%b unf=%b exp pc=0 valid=0 empty=1 full=0 ovf=0 unf=0",
                     bus.program_counter_o, bus.is_valid_o, bus.ras_empty_o,
                     bus.ras_full_o, bus.ras_overflow_o, bus.ras_underflow_o);
        end
        reset_n_i = 1'b1;
        #1;
        checks++;
        if (bus.is_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL valid_before_edge got=%b exp=0", bus.is_valid_o);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (bus.program_counter_o !== 32'(2 * i) || bus.is_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_idle%0d pc=%h valid=%b exp pc=%h valid=1",
                         i, bus.program_counter_o, bus.is_valid_o, 32'(2 * i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h10; exp_pc[2] = 32'h12;
        redirect(32'h10);
        checks++;
        if (bus.program_counter_o !== 32'h10) begin
            errors++;
            $display("FAIL redirect_to_10 pc=%h exp=00000010", bus.program_counter_o);
        end
        for (int i = 0; i < 3; i++) begin
            bus.stall_i = (i < 2);
            tick();
            checks++;
            if (bus.program_counter_o !== exp_pc[i]) begin
                errors++;
                $display("FAIL stall_step%0d pc=%h exp=%h", i, bus.program_counter_o, exp_pc[i]);
            end
        end
    endtask

    task automatic test_call_ret();
        redirect(32'h20);
        call_to(32'h100);
        checks++;
        if (bus.program_counter_o !== 32'h100 || bus.ras_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL call_push pc=%h empty=%b exp pc=00000100 empty=0",
                     bus.program_counter_o, bus.ras_empty_o);
        end
        bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h22 || bus.ras_empty_o !== 1'b1 ||
            bus.ras_underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ret_pop pc=%h empty=%b unf=%b exp pc=00000022 empty=1 unf=0",
                     bus.program_counter_o, bus.ras_empty_o, bus.ras_underflow_o);
        end
        // call_i without take_branch_i must not push
        bus.call_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h24 || bus.ras_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL call_no_branch pc=%h empty=%b exp pc=00000024 empty=1",
                     bus.program_counter_o, bus.ras_empty_o);
        end
    endtask

    task automatic test_priority();
        redirect(32'h60);
        call_to(32'h200);
        bus.wb_redirect_i = 1'b1; bus.wb_pc_i = 32'h400;
        bus.take_branch_i = 1'b1; bus.branch_pc_i = 32'h80;
        bus.call_i = 1'b1; bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h400 || bus.ras_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL redirect_priority pc=%h empty=%b exp pc=00000400 empty=0",
                     bus.program_counter_o, bus.ras_empty_o);
        end
        // stall beats ret: PC held, RAS untouched
        bus.stall_i = 1'b1; bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h400 || bus.ras_empty_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_over_ret pc=%h empty=%b exp pc=00000400 empty=0",
                     bus.program_counter_o, bus.ras_empty_o);
        end
        bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h62 || bus.ras_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL ras_kept_one pc=%h empty=%b exp pc=00000062 empty=1",
                     bus.program_counter_o, bus.ras_empty_o);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
`ifdef PC_SEQ_RAS_WRAP_EN
        exp_ret[0] = 32'h42; exp_ret[1] = 32'h32; exp_ret[2] = 32'h22; exp_ret[3] = 32'h12;
`else
        exp_ret[0] = 32'h32; exp_ret[1] = 32'h22; exp_ret[2] = 32'h12; exp_ret[3] = 32'h02;
`endif
        redirect(32'h0);
        for (int i = 1; i <= 5; i++) begin
            call_to(32'(i * 16));
            checks++;
            if (bus.program_counter_o !== 32'(i * 16) ||
                bus.ras_overflow_o !== (i == 5) ||
                bus.ras_full_o !== (i >= 4)) begin
                errors++;
                $display("FAIL call%0d pc=%h ovf=%b full=%b exp pc=%h ovf=%b full=%b",
                         i, bus.program_counter_o, bus.ras_overflow_o, bus.ras_full_o,
                         32'(i * 16), (i == 5), (i >= 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.ret_i = 1'b1;
            tick();
            checks++;
            if (bus.program_counter_o !== exp_ret[i] || bus.ras_overflow_o !== 1'b0) begin
                errors++;
                $display("FAIL ret%0d pc=%h ovf=%b exp pc=%h ovf=0",
                         i, bus.program_counter_o, bus.ras_overflow_o, exp_ret[i]);
            end
        end
        checks++;
        if (bus.ras_empty_o !== 1'b1 || bus.ras_full_o !== 1'b0) begin
            errors++;
            $display("FAIL drained empty=%b full=%b exp empty=1 full=0",
                     bus.ras_empty_o, bus.ras_full_o);
        end
    endtask

    task automatic test_underflow();
        redirect(32'h50);
        bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h52 || bus.ras_underflow_o !== 1'b1) begin
            errors++;
            $display("FAIL underflow pc=%h unf=%b exp pc=00000052 unf=1",
                     bus.program_counter_o, bus.ras_underflow_o);
        end
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h54 || bus.ras_underflow_o !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse pc=%h unf=%b exp pc=00000054 unf=0",
                     bus.program_counter_o, bus.ras_underflow_o);
        end
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFE);
        call_to(32'h300);
        bus.ret_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_push pc=%h exp=00000000", bus.program_counter_o);
        end
        redirect(32'hFFFF_FFFE);
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_seq pc=%h exp=00000000", bus.program_counter_o);
        end
    endtask

    task automatic test_reset_mid();
        redirect(32'h700);
        call_to(32'h800);
        #2;
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (bus.program_counter_o !== 32'h0 || bus.is_valid_o !== 1'b0 ||
            bus.ras_empty_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset pc=%h valid=%b empty=%b exp pc=0 valid=0 empty=1",
                     bus.program_counter_o, bus.is_valid_o, bus.ras_empty_o);
        end
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        tick();
        checks++;
        if (bus.program_counter_o !== 32'h2 || bus.is_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL after_reset pc=%h valid=%b exp pc=00000002 valid=1",
                     bus.program_counter_o, bus.is_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_call_ret();
        test_priority();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
